// File: rtl/load_store_unit.sv
// Data-memory initiator for the MEM stage: sizes, lane-aligns and, when an access
// straddles a word boundary, splits loads/stores into two word transactions.
module load_store_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC0  = 3'd1,
        ACC1  = 3'd2,
        LWAIT = 3'd3,
        RESP  = 3'd4
    } state_t;

    function automatic logic legal_f(input logic store, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: legal_f = 1'b1;
            3'b100, 3'b101:         legal_f = ~store;
            default:                legal_f = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] size_f(input logic [1:0] sz);
        case (sz)
            2'b00:   size_f = 4'd1;
            2'b01:   size_f = 4'd2;
            default: size_f = 4'd4;
        endcase
    endfunction

    function automatic logic [7:0] mask_f(input logic [1:0] sz);
        case (sz)
            2'b00:   mask_f = 8'h01;
            2'b01:   mask_f = 8'h03;
            default: mask_f = 8'h0F;
        endcase
    endfunction

    state_t                state_r;
    logic                  store_r;
    logic [2:0]            funct3_r;
    logic [1:0]            off_r;
    logic                  cross_r;
    logic [DM_ADDRESS-1:0] word1_r;
    logic [DATA_W-1:0]     wdata1_r;
    logic [3:0]            wstrb1_r;
    logic [DATA_W-1:0]     word0_r;

    logic                  req_ready_r;
    logic                  rsp_valid_r;
    logic [DATA_W-1:0]     rsp_rdata_r;
    logic                  rsp_err_r;
    logic                  mem_re_r;
    logic                  mem_we_r;
    logic [DM_ADDRESS-1:0] mem_addr_r;
    logic [DATA_W-1:0]     mem_wdata_r;
    logic [3:0]            mem_wstrb_r;

    logic [3:0]            size_s;
    logic [1:0]            off_s;
    logic                  cross_s;
    logic                  legal_s;
    logic [7:0]            strb_s;
    logic [2*DATA_W-1:0]   lanes_s;
    logic [2*DATA_W-1:0]   lanes_m_s;
    logic [DM_ADDRESS-1:0] word0_s;
    logic [DM_ADDRESS-1:0] word1_s;

    // Request decode: size, crossing test, word addresses, lane-aligned store data and strobes
    always_comb begin
        size_s    = size_f(req_funct3[1:0]);
        off_s     = req_addr[1:0];
        cross_s   = (({2'b00, off_s} + size_s) > 4'd4);
        legal_s   = legal_f(req_store, req_funct3);
        strb_s    = mask_f(req_funct3[1:0]) << off_s;
        lanes_s   = {{DATA_W{1'b0}}, req_wdata} << {off_s, 3'b000};
        lanes_m_s = {(2*DATA_W){1'b0}};
        for (int i = 0; i < 8; i++) begin
            if (strb_s[i]) begin
                lanes_m_s[8*i +: 8] = lanes_s[8*i +: 8];
            end else begin
                lanes_m_s[8*i +: 8] = 8'h00;
            end
        end
        word0_s = {req_addr[DM_ADDRESS-1:2], 2'b00};
        word1_s = word0_s + DM_ADDRESS'(3'd4);
    end

    logic [DATA_W-1:0] w0_s;
    logic [DATA_W-1:0] w1_s;
    logic [DATA_W-1:0] shifted_s;
    logic [DATA_W-1:0] load_s;

    // Load extraction from the final read word (plus the captured first word when split)
    always_comb begin
        if (cross_r) begin
            w0_s = word0_r;
            w1_s = mem_rdata;
        end else begin
            w0_s = mem_rdata;
            w1_s = {DATA_W{1'b0}};
        end
        shifted_s = DATA_W'({w1_s, w0_s} >> {off_r, 3'b000});
        case (funct3_r)
            3'b000:  load_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
            3'b001:  load_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b010:  load_s = shifted_s;
            3'b100:  load_s = {24'h000000, shifted_s[7:0]};
            3'b101:  load_s = {16'h0000, shifted_s[15:0]};
            default: load_s = {DATA_W{1'b0}};
        endcase
    end

    // Access sequencer with all bus and response outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            store_r     <= 1'b0;
            funct3_r    <= 3'b000;
            off_r       <= 2'b00;
            cross_r     <= 1'b0;
            word1_r     <= {DM_ADDRESS{1'b0}};
            wdata1_r    <= {DATA_W{1'b0}};
            wstrb1_r    <= 4'b0000;
            word0_r     <= {DATA_W{1'b0}};
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {DM_ADDRESS{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_wstrb_r <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        store_r     <= req_store;
                        funct3_r    <= req_funct3;
                        off_r       <= off_s;
                        cross_r     <= cross_s;
                        word1_r     <= word1_s;
                        req_ready_r <= 1'b0;
                        if (legal_s) begin
                            state_r     <= ACC0;
                            mem_re_r    <= ~req_store;
                            mem_we_r    <= req_store;
                            mem_addr_r  <= word0_s;
                            if (req_store) begin
                                mem_wdata_r <= lanes_m_s[DATA_W-1:0];
                                mem_wstrb_r <= strb_s[3:0];
                                wdata1_r    <= lanes_m_s[2*DATA_W-1:DATA_W];
                                wstrb1_r    <= strb_s[7:4];
                            end else begin
                                mem_wdata_r <= {DATA_W{1'b0}};
                                mem_wstrb_r <= 4'b0000;
                                wdata1_r    <= {DATA_W{1'b0}};
                                wstrb1_r    <= 4'b0000;
                            end
                        end else begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= {DATA_W{1'b0}};
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ACC0: begin
                    if (cross_r) begin
                        state_r     <= ACC1;
                        mem_addr_r  <= word1_r;
                        mem_wdata_r <= wdata1_r;
                        mem_wstrb_r <= wstrb1_r;
                    end else begin
                        mem_re_r    <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= {DM_ADDRESS{1'b0}};
                        mem_wdata_r <= {DATA_W{1'b0}};
                        mem_wstrb_r <= 4'b0000;
                        if (store_r) begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            rsp_rdata_r <= {DATA_W{1'b0}};
                        end else begin
                            state_r <= LWAIT;
                        end
                    end
                end
                ACC1: begin
                    // mem_rdata now carries the word0 read issued in ACC0
                    word0_r     <= mem_rdata;
                    mem_re_r    <= 1'b0;
                    mem_we_r    <= 1'b0;
                    mem_addr_r  <= {DM_ADDRESS{1'b0}};
                    mem_wdata_r <= {DATA_W{1'b0}};
                    mem_wstrb_r <= 4'b0000;
                    if (store_r) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= {DATA_W{1'b0}};
                    end else begin
                        state_r <= LWAIT;
                    end
                end
                LWAIT: begin
                    state_r     <= RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= load_s;
                end
                RESP: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    req_ready_r <= 1'b1;
                    mem_re_r    <= 1'b0;
                    mem_we_r    <= 1'b0;
                    mem_addr_r  <= {DM_ADDRESS{1'b0}};
                    mem_wdata_r <= {DATA_W{1'b0}};
                    mem_wstrb_r <= 4'b0000;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign mem_re    = mem_re_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected bus
// transactions and responses; a negedge monitor pops and compares them.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [8:0]  req_addr = 9'h000;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_re;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h5A5A_5A5A;

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: one-cycle read latency, filler data when not reading
    logic [31:0] mem [0:127] = '{default: 32'h0};
    logic        poke_en = 1'b0;
    logic [6:0]  poke_idx = 7'd0;
    logic [31:0] poke_data = 32'h0;

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_data;
        if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_wstrb[i]) mem[mem_addr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
        if (mem_re) mem_rdata <= mem[mem_addr[8:2]];
        else        mem_rdata <= 32'h5A5A_5A5A;
    end

    typedef struct { logic we; logic [8:0] addr; logic [31:0] wdata; logic [3:0] strb; int cyc; } mexp_t;
    typedef struct { logic [31:0] rdata; logic err; int cyc; } rexp_t;
    mexp_t mq[$];
    rexp_t rq[$];
    mexp_t me;
    rexp_t re;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: bus transactions and responses checked against the scoreboard
    always @(negedge clk) begin
        check("mem_exclusive", 32'(mem_re & mem_we), 32'd0);
        if (mem_re || mem_we) begin
            if (mq.size() == 0) begin
                total++; bad++;
                $display("FAIL mem_unexpected: got re=%0d we=%0d addr=%h want no access (cycle %0d)",
                         mem_re, mem_we, mem_addr, cyc);
            end else begin
                me = mq.pop_front();
                check("mem_we", 32'(mem_we), 32'(me.we));
                check("mem_re", 32'(mem_re), 32'(!me.we));
                check("mem_addr", 32'(mem_addr), 32'(me.addr));
                check("mem_wdata", mem_wdata, me.wdata);
                check("mem_wstrb", 32'(mem_wstrb), 32'(me.strb));
                check("mem_cycle", 32'(cyc), 32'(me.cyc));
            end
        end else begin
            check("idle_addr", 32'(mem_addr), 32'd0);
            check("idle_wdata", mem_wdata, 32'd0);
            check("idle_wstrb", 32'(mem_wstrb), 32'd0);
        end
        if (rsp_valid) begin
            if (rq.size() == 0) begin
                total++; bad++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=%h want none (cycle %0d)", rsp_rdata, cyc);
            end else begin
                re = rq.pop_front();
                check("rsp_rdata", rsp_rdata, re.rdata);
                check("rsp_err", 32'(rsp_err), 32'(re.err));
                check("rsp_cycle", 32'(cyc), 32'(re.cyc));
            end
        end
    end

    task automatic exp_mem(input logic we, input logic [8:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input int c);
        mq.push_back('{we, a, wd, st, c});
    endtask

    task automatic exp_rsp(input logic [31:0] rd, input logic err, input int c);
        rq.push_back('{rd, err, c});
    endtask

    task automatic poke(input logic [6:0] idx, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Drive one request; returns the accept cycle with the bench #1 past the accept edge
    task automatic send(input logic st, input logic [2:0] f3, input logic [8:0] a,
                        input logic [31:0] wd, output int t);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: req_ready=0 want 1 (cycle %0d)", cyc);
        end
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        t = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_store = ~st; req_funct3 = 3'b111;
        req_addr = 9'h1AB; req_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mq.size() != 0 || rq.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        poke(7'd4, 32'hDEAD_BEEF);
        poke(7'd127, 32'hAB00_0000);
        poke(7'd0, 32'h0000_00CD);
        @(negedge clk);
        reset = 1'b0;

        // aligned LW
        send(1'b0, 3'b010, 9'h010, 32'h0, t);
        exp_mem(1'b0, 9'h010, 32'h0, 4'b0000, t + 1);
        exp_rsp(32'hDEAD_BEEF, 1'b0, t + 3);
        wait_idle();

        // byte loads with sign and zero extension
        poke(7'd4, 32'h8012_3456);
        send(1'b0, 3'b000, 9'h013, 32'h0, t);
        exp_mem(1'b0, 9'h010, 32'h0, 4'b0000, t + 1);
        exp_rsp(32'hFFFF_FF80, 1'b0, t + 3);
        wait_idle();
        send(1'b0, 3'b100, 9'h013, 32'h0, t);
        exp_mem(1'b0, 9'h010, 32'h0, 4'b0000, t + 1);
        exp_rsp(32'h0000_0080, 1'b0, t + 3);
        wait_idle();

        // SB with junk upper bits: only lane 1 carries data; ready returns at T+3
        send(1'b1, 3'b000, 9'h011, 32'h1234_56A5, t);
        exp_mem(1'b1, 9'h010, 32'h0000_A500, 4'b0010, t + 1);
        exp_rsp(32'h0, 1'b0, t + 2);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("store_ready_timing", 32'(req_ready), (k == 3) ? 32'd1 : 32'd0);
        end
        wait_idle();
        send(1'b0, 3'b010, 9'h010, 32'h0, t);
        exp_mem(1'b0, 9'h010, 32'h0, 4'b0000, t + 1);
        exp_rsp(32'h8012_A556, 1'b0, t + 3);
        wait_idle();
        send(1'b0, 3'b001, 9'h012, 32'h0, t);
        exp_mem(1'b0, 9'h010, 32'h0, 4'b0000, t + 1);
        exp_rsp(32'hFFFF_8012, 1'b0, t + 3);
        wait_idle();

        // misaligned SW split over two words, then read back as a crossing LW
        send(1'b1, 3'b010, 9'h006, 32'h1122_3344, t);
        exp_mem(1'b1, 9'h004, 32'h3344_0000, 4'b1100, t + 1);
        exp_mem(1'b1, 9'h008, 32'h0000_1122, 4'b0011, t + 2);
        exp_rsp(32'h0, 1'b0, t + 3);
        wait_idle();
        send(1'b0, 3'b010, 9'h006, 32'h0, t);
        exp_mem(1'b0, 9'h004, 32'h0, 4'b0000, t + 1);
        exp_mem(1'b0, 9'h008, 32'h0, 4'b0000, t + 2);
        exp_rsp(32'h1122_3344, 1'b0, t + 4);
        wait_idle();

        // SH to upper half, LHU back
        send(1'b1, 3'b001, 9'h00A, 32'h0000_BEEF, t);
        exp_mem(1'b1, 9'h008, 32'hBEEF_0000, 4'b1100, t + 1);
        exp_rsp(32'h0, 1'b0, t + 2);
        wait_idle();
        send(1'b0, 3'b101, 9'h00A, 32'h0, t);
        exp_mem(1'b0, 9'h008, 32'h0, 4'b0000, t + 1);
        exp_rsp(32'h0000_BEEF, 1'b0, t + 3);
        wait_idle();

        // halfword load wrapping from the top word to word 0
        send(1'b0, 3'b001, 9'h1FF, 32'h0, t);
        exp_mem(1'b0, 9'h1FC, 32'h0, 4'b0000, t + 1);
        exp_mem(1'b0, 9'h000, 32'h0, 4'b0000, t + 2);
        exp_rsp(32'hFFFF_CDAB, 1'b0, t + 4);
        wait_idle();
        send(1'b0, 3'b101, 9'h1FF, 32'h0, t);
        exp_mem(1'b0, 9'h1FC, 32'h0, 4'b0000, t + 1);
        exp_mem(1'b0, 9'h000, 32'h0, 4'b0000, t + 2);
        exp_rsp(32'h0000_CDAB, 1'b0, t + 4);
        wait_idle();

        // illegal funct3: immediate error, no memory access
        send(1'b0, 3'b011, 9'h010, 32'h0, t);
        exp_rsp(32'h0, 1'b1, t + 1);
        wait_idle();
        send(1'b1, 3'b100, 9'h010, 32'hFFFF_FFFF, t);
        exp_rsp(32'h0, 1'b1, t + 1);
        wait_idle();

        // reset before the second half of a crossing store can be issued
        send(1'b1, 3'b010, 9'h00E, 32'hCAFE_F00D, t);
        exp_mem(1'b1, 9'h00C, 32'hF00D_0000, 4'b1100, t + 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 32'(req_ready), 32'd1);
        check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_reset_mem_we", 32'(mem_we), 32'd0);
        repeat (4) @(negedge clk);
        send(1'b0, 3'b010, 9'h010, 32'h0, t);
        exp_mem(1'b0, 9'h010, 32'h0, 4'b0000, t + 1);
        exp_rsp(32'h8012_A556, 1'b0, t + 3);
        wait_idle();
        send(1'b0, 3'b010, 9'h00C, 32'h0, t);
        exp_mem(1'b0, 9'h00C, 32'h0, 4'b0000, t + 1);
        exp_rsp(32'hF00D_0000, 1'b0, t + 3);
        wait_idle();

        check("mem_queue_drained", 32'(mq.size()), 32'd0);
        check("rsp_queue_drained", 32'(rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
